// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access size encoding,
// FSM states, lane geometry and small size helpers.
package lsu_pkg;

  localparam int unsigned MAX_BEATS = 2;
  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = 8;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BEAT0 = 2'b01,
    S_BEAT1 = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic [LANES-1:0] size_mask(input size_e size);
    case (size)
      SZ_BYTE: size_mask = 4'b0001;
      SZ_HALF: size_mask = 4'b0011;
      SZ_WORD: size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // An access needs a second beat when it runs past the end of its word.
  function automatic logic crosses_word(input logic [1:0] offset, input size_e size);
    crosses_word = ({1'b0, offset} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store mask/data for either beat, and the
// load extractor that shifts the two-beat window down and extends it.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]       offset,
  input  size_e            size,
  input  logic             beat1,
  input  logic [31:0]      wdata,
  output logic [LANES-1:0] mask,
  output logic [31:0]      wdata_lane,
  input  logic [31:0]      rd_lo,
  input  logic [31:0]      rd_hi,
  input  logic             ld_unsigned,
  output logic [31:0]      rdata
);

  logic [LANES-1:0] n_mask;
  logic [5:0]       sh0;
  logic [5:0]       sh1;
  logic [31:0]      raw;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    n_mask     = size_mask(size);
    sh0        = {1'b0, offset, 3'b000};
    sh1        = 6'd32 - sh0;
    mask       = '0;
    wdata_lane = '0;
    if (beat1) begin
      mask       = n_mask >> (3'd4 - {1'b0, offset});
      wdata_lane = wdata >> sh1;
    end else begin
      mask       = n_mask << offset;
      wdata_lane = wdata << sh0;
    end

    raw = 32'({rd_hi, rd_lo} >> sh0);
    case (size)
      SZ_BYTE: rdata = ld_unsigned ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: rdata = ld_unsigned ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, issues one or two
// registered word-aligned memory beats, then pulses a single-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_data_mask,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [31:0] mem_read_data
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  size_e       size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;
  logic        split_q, split_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata0_q, rdata0_d;

  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_mask_q, mem_mask_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;

  size_e       req_size_e;
  logic        req_split;
  logic        req_err;

  logic [1:0]  al_off;
  size_e       al_size;
  logic [31:0] al_wdata;
  logic [31:0] al_lo;
  logic [31:0] al_hi;
  logic [3:0]  al_mask;
  logic [31:0] al_wlane;
  logic [31:0] al_rdata;

  assign req_size_e = size_e'(req_size);
  assign req_split  = crosses_word(req_addr[1:0], req_size_e);
  assign req_err    = (req_size_e == SZ_ILLEGAL) || (req_split && !SPLIT_MISALIGNED);

  // In IDLE the aligner looks at the incoming request so beat 0 can be
  // registered on the accept edge; afterwards it works from the held copy.
  assign al_off   = (state_q == S_IDLE) ? req_addr[1:0] : off_q;
  assign al_size  = (state_q == S_IDLE) ? req_size_e    : size_q;
  assign al_wdata = (state_q == S_IDLE) ? req_wdata     : wdata_q;
  assign al_lo    = (state_q == S_BEAT1) ? rdata0_q      : mem_read_data;
  assign al_hi    = (state_q == S_BEAT1) ? mem_read_data : 32'h0;

  lsu_lane_align u_align (
    .offset      (al_off),
    .size        (al_size),
    .beat1       (state_q == S_BEAT0),
    .wdata       (al_wdata),
    .mask        (al_mask),
    .wdata_lane  (al_wlane),
    .rd_lo       (al_lo),
    .rd_hi       (al_hi),
    .ld_unsigned (uns_q),
    .rdata       (al_rdata)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    off_d       = off_q;
    split_d     = split_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_mask_d  = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size_e;
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          split_d = req_split;
          wdata_d = req_wdata;
          if (req_err) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_BEAT0;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_we_d    = req_we;
            mem_re_d    = !req_we;
            mem_mask_d  = req_we ? al_mask : 4'b1111;
            mem_wdata_d = req_we ? al_wlane : 32'h0;
          end
        end
      end
      S_BEAT0: begin
        if (split_q) begin
          state_d     = S_BEAT1;
          rdata0_d    = mem_read_data;
          mem_addr_d  = mem_addr_q + 32'd4;
          mem_we_d    = we_q;
          mem_re_d    = !we_q;
          mem_mask_d  = we_q ? al_mask : 4'b1111;
          mem_wdata_d = we_q ? al_wlane : 32'h0;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : al_rdata;
        end
      end
      S_BEAT1: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'h0 : al_rdata;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      off_q       <= '0;
      split_q     <= 1'b0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      off_q       <= off_d;
      split_q     <= split_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign req_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_data_mask  = mem_mask_q;
  assign mem_write_en   = mem_we_q;
  assign mem_read_en    = mem_re_q;

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter SPLIT_MISALIGNED, default 1; 1 = split misaligned accesses into two beats, 0 = flag them as errors.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  pipeline request present.
REQ-006 req_ready  out  1  request accepted at the edge where valid and ready are both high.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-013 rsp_rdata  out  32  extended load result; 0 for stores and errors.
REQ-014 rsp_err  out  1  misaligned (when SPLIT_MISALIGNED=0) or illegal size.
REQ-015 mem_addr  out  32  word-aligned byte address; bits [1:0] are always 00.
REQ-016 mem_write_data  out  32  lane-positioned store data.
REQ-017 mem_data_mask  out  4  byte-lane enables.
REQ-018 mem_write_en  out  1  store beat.
REQ-019 mem_read_en  out  1  load beat.
REQ-020 mem_read_data  in  32  combinational word from memory; bits [8k+7:8k] hold byte k.

Function
REQ-021 FSM states SHALL be IDLE, BEAT0, BEAT1 and RESP; req_ready SHALL be high only in IDLE.
REQ-022 Accepting a request SHALL register all req_* fields; the next state is BEAT0, or RESP if the request is an error.
REQ-023 BEAT0 SHALL drive mem_addr={addr[31:2],2'b00}; BEAT1 SHALL drive mem_addr+4, wrapping modulo 2^32.
REQ-024 Let o=addr[1:0] and n=1/2/4 bytes; the access is split when o+n>4.
REQ-025 Store masks: beat0 = ((1<<n)-1)<<o truncated to 4 bits; beat1 = ((1<<n)-1)>>(4-o).
REQ-026 Store data: beat0 = wdata<<8o; beat1 = wdata>>8(4-o).
REQ-027 Loads SHALL drive mask 4'b1111 with mem_read_en=1 and mem_write_en=0.
REQ-028 mem_read_data SHALL be sampled at the clock edge ending each load beat.
REQ-029 Load result: ({beat1,beat0}>>8o) truncated to 8n bits, then sign- or zero-extended to 32 bits.
REQ-030 Transitions: BEAT0 goes to BEAT1 if split, else to RESP; BEAT1 goes to RESP; RESP goes to IDLE.
REQ-031 rsp_valid SHALL be high only in RESP; rsp_rdata and rsp_err SHALL be stable throughout RESP.
REQ-032 Latency from the accept edge: rsp_valid in cycle 2 unsplit, cycle 3 split, cycle 1 for errors.
REQ-033 Errors SHALL issue no memory beat and SHALL give rsp_err=1 and rsp_rdata=0.
REQ-034 Outside BEAT0/BEAT1: mem_write_en, mem_read_en, mem_data_mask, mem_addr and mem_write_data SHALL be 0.
REQ-035 All mem_* outputs SHALL be driven from registers, with no combinational path from req_* to mem_*.
REQ-036 req_valid while not in IDLE SHALL be ignored; requests are never queued.

Reset
REQ-037 While rst_n is low: state IDLE, req_ready=1, and every other output 0, applied asynchronously.
REQ-038 Reset mid-access SHALL abort the access: no remaining beat, no rsp_valid, and the request is lost.

Structure
REQ-039 Package lsu_pkg SHALL hold the size encoding enum, the FSM state enum, and the constants for beat count and lane width.
REQ-040 Sub-module lsu_lane_align SHALL be the combinational mask/shift generator for stores and the load extractor/extender.

Verification
REQ-041 Store byte 0xAB at 0x13: one beat, mem_addr 0x10, mask 4'b1000, wdata 0xAB000000; rsp_valid at cycle 2.
REQ-042 Load byte at 0x11 from memory word 0x00008000: signed gives 0xFFFFFF80, unsigned gives 0x00000080.
REQ-043 Load word at 0x06 with mem[0x4]=0x44332211 and mem[0x8]=0x88776655: beats at 0x4 then 0x8, rsp_rdata 0x66554433 at cycle 3.
REQ-044 Store half 0xBEEF at 0x0B: beat0 0x08, mask 1000, 0xEF000000; beat1 0x0C, mask 0001, 0x000000BE.
REQ-045 Word at 0xFFFFFFFE: beat1 mem_addr 0x00000000. With SPLIT_MISALIGNED=0, word at 0x02 gives no mem enables, rsp_err=1 at cycle 1; size 11 behaves the same.
REQ-046 rst_n pulsed low during BEAT1: mem enables drop immediately, no rsp_valid, req_ready=1 after release.
